// File: rtl/ks_pkg.sv
// rtl/ks_pkg.sv - shared helpers and stage record for the Kogge-Stone adder pipeline
package ks_pkg;

    localparam int MAXW = 64;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int t = 1; t < v; t = t * 2) r++;
        return r;
    endfunction

    function automatic int lat(input int width, input int pipe);
        return (pipe != 0) ? clog2(width) + 1 : 1;
    endfunction

    // Bit 0 of g already folds in the carry-in, so cin is only needed for sum bit 0.
    typedef struct packed {
        logic [MAXW-1:0] p;
        logic [MAXW-1:0] g;
        logic [MAXW-1:0] p_orig;
        logic            cin;
        logic            valid;
    } ks_stage_t;

    localparam int STAGE_BITS = $bits(ks_stage_t);

endpackage

// File: rtl/ks_level.sv
// rtl/ks_level.sv - one Kogge-Stone prefix level at distance DIST with optional register
module ks_level
    import ks_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1,
    parameter bit REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic [STAGE_BITS-1:0] stage_in,
    output logic [STAGE_BITS-1:0] stage_out
);

    ks_stage_t cur;
    ks_stage_t nxt;

    assign cur = ks_stage_t'(stage_in);

    // A predecessor below DIST already spans down to bit 0, so only its generate matters.
    always_comb begin
        nxt = cur;
        for (int i = DIST; i < WIDTH; i++) begin
            if (i - DIST < DIST) begin
                nxt.g[i] = cur.g[i] | (cur.p[i] & cur.g[i-DIST]);
            end else begin
                nxt.g[i] = cur.g[i] | (cur.p[i] & cur.g[i-DIST]);
                nxt.p[i] = cur.p[i] & cur.p[i-DIST];
            end
        end
    end

    if (REG) begin : g_reg
        logic [STAGE_BITS-1:0] q;
        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (advance) begin
                q <= nxt;
            end
        end
        assign stage_out = q;
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = ^{clk, rst, advance};
        assign stage_out  = nxt;
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// rtl/ks_adder_pipe.sv - pipelined Kogge-Stone add/subtract with valid/ready handshake
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PIPE  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c0,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);

    localparam int LEVELS = clog2(WIDTH);

    logic                  advance;
    ks_stage_t             pre;
    ks_stage_t             last;
    logic [WIDTH-1:0]      b_eff;
    logic                  c_eff;
    logic [WIDTH-1:0]      carry;
    logic [STAGE_BITS-1:0] chain [0:LEVELS];

    assign advance = !o_valid || i_ready;
    assign o_ready = advance;

    assign b_eff = i_sub ? ~i_b : i_b;
    assign c_eff = i_c0 ^ i_sub;

    always_comb begin
        pre                   = '0;
        pre.p[WIDTH-1:0]      = i_a ^ b_eff;
        pre.g[WIDTH-1:0]      = i_a & b_eff;
        pre.g[0]              = (i_a[0] & b_eff[0]) | ((i_a[0] ^ b_eff[0]) & c_eff);
        pre.p_orig[WIDTH-1:0] = i_a ^ b_eff;
        pre.cin               = c_eff;
        pre.valid             = i_valid;
    end

    if (PIPE != 0) begin : g_pre_reg
        logic [STAGE_BITS-1:0] q;
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                q <= '0;
            end else if (advance) begin
                q <= pre;
            end
        end
        assign chain[0] = q;
    end else begin : g_pre_comb
        assign chain[0] = pre;
    end

    // Without PIPE only the last level keeps its register, giving a single output stage.
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        ks_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << k),
            .REG   ((PIPE != 0) || (k == LEVELS - 1))
        ) u_level (
            .clk       (i_clk),
            .rst       (i_rst),
            .advance   (advance),
            .stage_in  (chain[k]),
            .stage_out (chain[k+1])
        );
    end

    assign last  = ks_stage_t'(chain[LEVELS]);
    assign carry = last.g[WIDTH-1:0];

    assign o_valid = last.valid;
    assign o_sum   = last.p_orig[WIDTH-1:0] ^ {carry[WIDTH-2:0], last.cin};
    assign o_cout  = carry[WIDTH-1];
    assign o_ovf   = carry[WIDTH-1] ^ carry[WIDTH-2];

    logic unused_bits;
    assign unused_bits = ^{last.p, last.g, last.p_orig};

endmodule

// File: tb/tb_ks_adder_pipe.sv
// tb/tb_ks_adder_pipe.sv - scoreboard bench for ks_adder_pipe against an arithmetic model
module tb_ks_adder_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 1
);

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    localparam int LAT = (PIPE != 0) ? $clog2(WIDTH) + 1 : 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             beat_valid = 1'b0;
    logic             ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             c0 = 1'b0;
    logic             sub = 1'b0;
    logic             res_valid;
    logic             sink_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   delivered = 0;

    always #5 clk = ~clk;

    ks_adder_pipe #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (beat_valid),
        .o_ready (ready),
        .i_a     (a),
        .i_b     (b),
        .i_c0    (c0),
        .i_sub   (sub),
        .o_valid (res_valid),
        .i_ready (sink_ready),
        .o_sum   (sum),
        .o_cout  (cout),
        .o_ovf   (ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                                   input logic xc0, input logic xsub);
        exp_t             e;
        logic [WIDTH+1:0] sa, sb, ua, ub, ci, sr, ur;
        sa = {{2{xa[WIDTH-1]}}, xa};
        sb = {{2{xb[WIDTH-1]}}, xb};
        ua = {2'b00, xa};
        ub = {2'b00, xb};
        ci = {{(WIDTH+1){1'b0}}, xc0};
        if (xsub) begin
            sr     = sa - sb - ci;
            e.cout = (ua >= ub + ci);
        end else begin
            sr     = sa + sb + ci;
            ur     = ua + ub + ci;
            e.cout = ur[WIDTH];
        end
        e.sum = '0;
        e.sum[WIDTH-1:0] = sr[WIDTH-1:0];
        e.ovf = sr[WIDTH] ^ sr[WIDTH-1];
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(WIDTH-1){1'b0}}};
            3:       return {1'b0, {(WIDTH-1){1'b1}}};
            default: return r[WIDTH-1:0];
        endcase
    endfunction

    task automatic cycle(input logic v, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                         input logic xc0, input logic xsub, input logic xrdy, output logic acc);
        @(negedge clk);
        rst        = 1'b0;
        beat_valid = v;
        a          = xa;
        b          = xb;
        c0         = xc0;
        sub        = xsub;
        sink_ready = xrdy;
        #1;
        acc = v && ready;
        if (acc) q.push_back(model(xa, xb, xc0, xsub));
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic rst_cycle();
        @(negedge clk);
        rst        = 1'b1;
        beat_valid = 1'b1;
        a          = rand_op();
        b          = rand_op();
        sink_ready = 1'b1;
        q.delete();
        #1;
    endtask

    task automatic check_idle(input string tag);
        idle(1);
        chk({tag, "_valid"}, {63'd0, res_valid}, 64'd0);
        chk({tag, "_sum"}, {{(64-WIDTH){1'b0}}, sum}, 64'd0);
        chk({tag, "_cout"}, {63'd0, cout}, 64'd0);
        chk({tag, "_ovf"}, {63'd0, ovf}, 64'd0);
        chk({tag, "_ready"}, {63'd0, ready}, 64'd1);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && q.size() != 0; i++) idle(1);
        idle(2);
        chk({tag, "_drain"}, 64'(q.size()), 64'd0);
    endtask

    task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                        input logic xc0, input logic xsub);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) cycle(1'b1, xa, xb, xc0, xsub, 1'b1, acc);
        chk("send_accepted", {63'd0, acc}, 64'd1);
    endtask

    // Monitor: pops one expectation per output transfer and watches stall stability.
    initial begin
        logic             hold;
        logic [WIDTH-1:0] h_sum;
        logic             h_cout, h_ovf;
        exp_t             e;
        hold = 1'b0;
        h_sum = '0;
        h_cout = 1'b0;
        h_ovf = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                hold = 1'b0;
            end else begin
                chk("o_ready", {63'd0, ready}, {63'd0, (!res_valid || sink_ready)});
                if (hold) begin
                    chk("hold_valid", {63'd0, res_valid}, 64'd1);
                    chk("hold_sum", {{(64-WIDTH){1'b0}}, sum}, {{(64-WIDTH){1'b0}}, h_sum});
                    chk("hold_cout", {63'd0, cout}, {63'd0, h_cout});
                    chk("hold_ovf", {63'd0, ovf}, {63'd0, h_ovf});
                end
                if (res_valid && sink_ready) begin
                    if (q.size() == 0) begin
                        chk("spurious_valid", {63'd0, res_valid}, 64'd0);
                    end else begin
                        e = q.pop_front();
                        chk("sum", {{(64-WIDTH){1'b0}}, sum}, e.sum);
                        chk("cout", {63'd0, cout}, {63'd0, e.cout});
                        chk("ovf", {63'd0, ovf}, {63'd0, e.ovf});
                        delivered++;
                    end
                end
                hold   = res_valid && !sink_ready;
                h_sum  = sum;
                h_cout = cout;
                h_ovf  = ovf;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   n, cyc, base;

        for (int i = 0; i < 3; i++) rst_cycle();
        check_idle("reset");

        // All-ones plus one: wraps to zero with carry-out; also measures latency.
        send('1, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0, 1'b0);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (res_valid) break;
            n++;
        end
        chk("latency", 64'(n), 64'(LAT));
        drain("lat");

        send({1'b0, {(WIDTH-1){1'b1}}}, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0, 1'b0);
        send(WIDTH'(5), WIDTH'(7), 1'b0, 1'b1);
        send(WIDTH'(7), WIDTH'(5), 1'b1, 1'b1);
        send({1'b1, {(WIDTH-1){1'b0}}}, {{(WIDTH-1){1'b0}}, 1'b1}, 1'b0, 1'b1);
        send('0, '0, 1'b1, 1'b0);
        drain("directed");

        base = delivered;
        n = 0;
        cyc = 0;
        while (n < 20 && cyc < 200) begin
            cycle(1'b1, rand_op(), rand_op(), 1'($urandom), 1'($urandom),
                  !(cyc >= 6 && cyc < 9), acc);
            if (acc) n++;
            cyc++;
        end
        drain("backpressure");
        chk("bp_delivered", 64'(delivered - base), 64'd20);

        for (int i = 0; i < 3; i++) send(rand_op(), rand_op(), 1'($urandom), 1'($urandom));
        rst_cycle();
        check_idle("midreset");
        idle(LAT + 4);

        n = 0;
        cyc = 0;
        while (n < 10000 && cyc < 40000) begin
            cycle($urandom_range(0, 9) < 7, rand_op(), rand_op(), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 9) < 8, acc);
            if (acc) n++;
            cyc++;
        end
        chk("random_beats", 64'(n), 64'd10000);
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
